// File: rtl/wfg_drive_spi_mc.sv
// wfg_drive_spi_mc: single-word SPI master driven from an AXI-Stream source.
// A word is latched together with its configuration, waits for a pattern sync
// pulse, then is shifted out with programmable CPOL/CPHA/bit order/CS.
// Optional feature macro: WFG_DRIVE_SPI_MC_CS_HOLD_EN keeps CS asserted between
// the words of a packet (released after a tlast=1 word or on abort).
module wfg_drive_spi_mc #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int NUM_CS          = 4,
  parameter int DIV_WIDTH       = 8,
  localparam int LEN_W          = $clog2(AXIS_DATA_WIDTH),
  localparam int CS_W           = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       wfg_pat_sync_i,
  output logic                       wfg_axis_tready_o,
  input  logic                       wfg_axis_tvalid_i,
  input  logic                       wfg_axis_tlast_i,
  input  logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_i,
  input  logic                       ctrl_en_q_i,
  input  logic [DIV_WIDTH-1:0]       clkcfg_div_q_i,
  input  logic                       cfg_cpol_q_i,
  input  logic                       cfg_cpha_q_i,
  input  logic                       cfg_lsbfirst_q_i,
  input  logic                       cfg_sspol_q_i,
  input  logic [LEN_W-1:0]           cfg_frame_len_q_i,
  input  logic [CS_W-1:0]            cfg_cs_sel_q_i,
  output logic                       wfg_drive_spi_sclk_o,
  output logic                       wfg_drive_spi_sdo_o,
  output logic                       wfg_drive_spi_sdo_en_o,
  output logic [NUM_CS-1:0]          wfg_drive_spi_cs_no,
  output logic                       busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOADED,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;     // counts down H-1 .. 0 for one half period
  logic [LEN_W-1:0]     bit_q, bit_d;     // index of the bit being sent (0 = first)
  logic                 half_q, half_d;   // 0 = first half of a bit, 1 = second half
  logic                 hold_q, hold_d;   // CS kept asserted while idle between words

  // Shadow copy of the word and its configuration, frozen for the whole frame.
  logic [AXIS_DATA_WIDTH-1:0] sh_data_q, sh_data_d;
  logic                       sh_cpol_q, sh_cpol_d;
  logic                       sh_cpha_q, sh_cpha_d;
  logic                       sh_lsb_q, sh_lsb_d;
  logic                       sh_sspol_q, sh_sspol_d;
  logic [LEN_W-1:0]           sh_len_q, sh_len_d;
  logic [CS_W-1:0]            sh_sel_q, sh_sel_d;
  logic [DIV_WIDTH-1:0]       sh_div_q, sh_div_d;
`ifdef WFG_DRIVE_SPI_MC_CS_HOLD_EN
  logic                       sh_last_q, sh_last_d;
`else
  logic                       unused_tlast;
  assign unused_tlast = wfg_axis_tlast_i;
`endif

  // Registered outputs and their next values.
  logic              tready_q, tready_d;
  logic              busy_q, busy_d;
  logic              sclk_q, sclk_d;
  logic              sdo_q, sdo_d;
  logic              sdo_en_q, sdo_en_d;
  logic [NUM_CS-1:0] cs_q, cs_d;
  logic              framing, cs_act, cs_pol;
  logic [LEN_W-1:0]  bit_idx;

  // Next-state logic: word capture, sync wait, half-period sequencing, abort.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    half_d     = half_q;
    hold_d     = hold_q;
    sh_data_d  = sh_data_q;
    sh_cpol_d  = sh_cpol_q;
    sh_cpha_d  = sh_cpha_q;
    sh_lsb_d   = sh_lsb_q;
    sh_sspol_d = sh_sspol_q;
    sh_len_d   = sh_len_q;
    sh_sel_d   = sh_sel_q;
    sh_div_d   = sh_div_q;
`ifdef WFG_DRIVE_SPI_MC_CS_HOLD_EN
    sh_last_d  = sh_last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (wfg_axis_tvalid_i && tready_q) begin
          sh_data_d  = wfg_axis_tdata_i;
          sh_cpol_d  = cfg_cpol_q_i;
          sh_cpha_d  = cfg_cpha_q_i;
          sh_lsb_d   = cfg_lsbfirst_q_i;
          sh_sspol_d = cfg_sspol_q_i;
          sh_len_d   = cfg_frame_len_q_i;
          sh_sel_d   = cfg_cs_sel_q_i;
          sh_div_d   = clkcfg_div_q_i;
`ifdef WFG_DRIVE_SPI_MC_CS_HOLD_EN
          sh_last_d  = wfg_axis_tlast_i;
`endif
          state_d    = ST_LOADED;
        end
      end
      ST_LOADED: begin
        if (wfg_pat_sync_i) begin
          state_d = ST_SETUP;
          cnt_d   = sh_div_q;
          bit_d   = '0;
          half_d  = 1'b0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_SHIFT;
          cnt_d   = sh_div_q;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
          cnt_d = sh_div_q;
          if (!half_q) begin
            half_d = 1'b1;
          end else if (bit_q == sh_len_q) begin
            state_d = ST_HOLD;
          end else begin
            bit_d  = bit_q + LEN_W'(1);
            half_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
`ifdef WFG_DRIVE_SPI_MC_CS_HOLD_EN
          hold_d  = !sh_last_q;
`else
          hold_d  = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Disabling the core drops any word in flight and releases CS.
    if (!ctrl_en_q_i) begin
      hold_d = 1'b0;
      if (state_q != ST_IDLE) state_d = ST_IDLE;
    end
  end

  // Output values derived from the next state so every output is a flop.
  always_comb begin
    framing  = (state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD);
    tready_d = (state_d == ST_IDLE) && ctrl_en_q_i;
    busy_d   = (state_d != ST_IDLE);
    sdo_en_d = framing;
    cs_act   = framing || hold_d;
    cs_pol   = (state_d == ST_IDLE && !hold_d) ? cfg_sspol_q_i : sh_sspol_d;
    bit_idx  = sh_lsb_d ? bit_d : (sh_len_d - bit_d);
    sdo_d    = 1'b0;
    sclk_d   = sh_cpol_d;
    case (state_d)
      ST_IDLE:  sclk_d = cfg_cpol_q_i;
      ST_SETUP: sdo_d  = sh_data_d[bit_idx];
      ST_SHIFT: begin
        sdo_d  = sh_data_d[bit_idx];
        sclk_d = sh_cpol_d ^ sh_cpha_d ^ half_d;
      end
      ST_HOLD:  sdo_d  = sdo_q;
      default:  sdo_d  = 1'b0;
    endcase
  end

  // One CS line per index; only the selected in-range index goes active.
  generate
    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs
      assign cs_d[gi] = (cs_act && (sh_sel_d == CS_W'(gi))) ? cs_pol : ~cs_pol;
    end
  endgenerate

  // State, counters and shadow registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      half_q     <= 1'b0;
      hold_q     <= 1'b0;
      sh_data_q  <= '0;
      sh_cpol_q  <= 1'b0;
      sh_cpha_q  <= 1'b0;
      sh_lsb_q   <= 1'b0;
      sh_sspol_q <= 1'b0;
      sh_len_q   <= '0;
      sh_sel_q   <= '0;
      sh_div_q   <= '0;
`ifdef WFG_DRIVE_SPI_MC_CS_HOLD_EN
      sh_last_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      half_q     <= half_d;
      hold_q     <= hold_d;
      sh_data_q  <= sh_data_d;
      sh_cpol_q  <= sh_cpol_d;
      sh_cpha_q  <= sh_cpha_d;
      sh_lsb_q   <= sh_lsb_d;
      sh_sspol_q <= sh_sspol_d;
      sh_len_q   <= sh_len_d;
      sh_sel_q   <= sh_sel_d;
      sh_div_q   <= sh_div_d;
`ifdef WFG_DRIVE_SPI_MC_CS_HOLD_EN
      sh_last_q  <= sh_last_d;
`endif
    end
  end

  // Output registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tready_q <= 1'b0;
      busy_q   <= 1'b0;
      sclk_q   <= 1'b0;
      sdo_q    <= 1'b0;
      sdo_en_q <= 1'b0;
      cs_q     <= '1;
    end else begin
      tready_q <= tready_d;
      busy_q   <= busy_d;
      sclk_q   <= sclk_d;
      sdo_q    <= sdo_d;
      sdo_en_q <= sdo_en_d;
      cs_q     <= cs_d;
    end
  end

  assign wfg_axis_tready_o      = tready_q;
  assign busy_o                 = busy_q;
  assign wfg_drive_spi_sclk_o   = sclk_q;
  assign wfg_drive_spi_sdo_o    = sdo_q;
  assign wfg_drive_spi_sdo_en_o = sdo_en_q;
  assign wfg_drive_spi_cs_no    = cs_q;

endmodule

// File: tb/tb_wfg_drive_spi_mc.sv
// Testbench for wfg_drive_spi_mc: stimulus pushes the expected frame into a
// scoreboard queue; an SPI-slave monitor captures each frame and compares.
module tb_wfg_drive_spi_mc;
  localparam int W   = 16;
  localparam int NCS = 3;
  localparam int DW  = 3;
  localparam int LW  = $clog2(W);
  localparam int SW  = $clog2(NCS);

  logic           clk = 1'b0;
  logic           rst;
  logic           sync, tready, tvalid, tlast, ctrl_en;
  logic [W-1:0]   tdata;
  logic [DW-1:0]  div;
  logic           cpol, cpha, lsb, sspol;
  logic [LW-1:0]  flen;
  logic [SW-1:0]  sel;
  logic           sclk, sdo, sdo_en, busy;
  logic [NCS-1:0] cs_no;

  always #5 clk = ~clk;

  wfg_drive_spi_mc #(.AXIS_DATA_WIDTH(W), .NUM_CS(NCS), .DIV_WIDTH(DW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wfg_pat_sync_i(sync),
    .wfg_axis_tready_o(tready), .wfg_axis_tvalid_i(tvalid),
    .wfg_axis_tlast_i(tlast), .wfg_axis_tdata_i(tdata),
    .ctrl_en_q_i(ctrl_en), .clkcfg_div_q_i(div),
    .cfg_cpol_q_i(cpol), .cfg_cpha_q_i(cpha), .cfg_lsbfirst_q_i(lsb),
    .cfg_sspol_q_i(sspol), .cfg_frame_len_q_i(flen), .cfg_cs_sel_q_i(sel),
    .wfg_drive_spi_sclk_o(sclk), .wfg_drive_spi_sdo_o(sdo),
    .wfg_drive_spi_sdo_en_o(sdo_en), .wfg_drive_spi_cs_no(cs_no), .busy_o(busy)
  );

  typedef struct {
    logic [W-1:0]   bits;    // bits in transmission order, first bit most significant
    int             n;       // number of bits
    int             h;       // half period in clocks
    logic           cpol, cpha, sspol, last, abort;
    logic [NCS-1:0] cs_frame;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: the bit stream and CS pattern a slave should see.
  function automatic exp_t model(input logic [W-1:0] d, input int len, input logic cp,
                                 input logic ch, input logic lf, input logic sp,
                                 input int cs, input int dv, input logic lt, input logic ab);
    exp_t e;
    e.bits = '0;
    for (int k = 0; k <= len; k++) e.bits = {e.bits[W-2:0], (lf ? d[k] : d[len-k])};
    e.n = len + 1;
    e.h = dv + 1;
    e.cpol = cp; e.cpha = ch; e.sspol = sp; e.last = lt; e.abort = ab;
    for (int i = 0; i < NCS; i++) e.cs_frame[i] = (i == cs) ? sp : ~sp;
    return e;
  endfunction

  // Monitor: behaves as an SPI slave sampling on the mid-bit clock edge.
  logic     prev_en = 1'b0, prev_sclk = 1'b0, have = 1'b0;
  exp_t     cur;
  int       cyc = 0, en_cyc, ntrans, nbits, last_samp, space_err, cs_err, frame_no = 0;
  logic [W-1:0]   rx;
  logic [NCS-1:0] exp_post;

  always @(negedge clk) begin
    cyc++;
    if (sdo_en === 1'b1 && prev_en !== 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_frame", 32'd1, 32'd0);
        have = 1'b0;
      end else begin
        cur = sb_q.pop_front();
        have = 1'b1;
      end
      en_cyc = 0; ntrans = 0; nbits = 0; space_err = 0; cs_err = 0; rx = '0; last_samp = 0;
    end
    if (sdo_en === 1'b1 && have) begin
      en_cyc++;
      if (cs_no !== cur.cs_frame) cs_err++;
      if (sclk !== prev_sclk) begin
        ntrans++;
        if (sclk === (cur.cpha ? cur.cpol : ~cur.cpol)) begin
          nbits++;
          rx = {rx[W-2:0], sdo};
          if (nbits > 1 && (cyc - last_samp) != 2 * cur.h) space_err++;
          last_samp = cyc;
        end
      end
    end
    if (sdo_en !== 1'b1 && prev_en === 1'b1 && have) begin
      exp_post = {NCS{~sspol}};
`ifdef WFG_DRIVE_SPI_MC_CS_HOLD_EN
      if (!cur.abort && !cur.last) exp_post = cur.cs_frame;
`endif
      check("cs_in_frame", cs_err, 0);
      check("cs_after_frame", cs_no, exp_post);
      if (cur.abort) begin
        check("abort_short", (nbits < cur.n), 1);
      end else begin
        check("bit_count", nbits, cur.n);
        check("data", rx, cur.bits);
        check("frame_cycles", en_cyc, 2 * cur.h * (cur.n + 1));
        check("sclk_edges", ntrans, 2 * cur.n);
        check("edge_spacing", space_err, 0);
      end
      $display("frame %0d n=%0d h=%0d abort=%0d rx=%0h exp=%0h", frame_no, cur.n, cur.h,
               cur.abort, rx, cur.bits);
      frame_no++;
      have = 1'b0;
    end
    prev_en = sdo_en;
    prev_sclk = sclk;
  end

  task automatic send(input logic [W-1:0] d, input int len, input logic cp, input logic ch,
                      input logic lf, input logic sp, input int cs, input int dv,
                      input logic lt, input logic ab, input logic scramble);
    logic ok;
    @(negedge clk);
    tdata = d; flen = LW'(len); cpol = cp; cpha = ch; lsb = lf; sspol = sp;
    sel = SW'(cs); div = DW'(dv); tlast = lt; tvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tready === 1'b1) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tvalid = 1'b0;
    if (!ok) check("handshake_timeout", 32'd1, 32'd0);
    else sb_q.push_back(model(d, len, cp, ch, lf, sp, cs, dv, lt, ab));
    if (scramble) begin
      // Live configuration must not disturb the latched frame.
      cpol = 1'($urandom); cpha = 1'($urandom); lsb = 1'($urandom);
      flen = LW'($urandom); sel = SW'($urandom); div = DW'($urandom); tdata = W'($urandom);
    end
  endtask

  task automatic sync_pulse(input int gap);
    repeat (gap) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 3000; i++) begin
      if (busy === 1'b0) break;
      @(negedge clk);
    end
    if (i == 3000) check("busy_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input logic [W-1:0] d, input int len, input logic cp, input logic ch,
                     input logic lf, input logic sp, input int cs, input int dv,
                     input logic lt, input logic scramble);
    send(d, len, cp, ch, lf, sp, cs, dv, lt, 1'b0, scramble);
    sync_pulse($urandom_range(0, 3));
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic ref_sclk;
    rst = 1'b1; sync = 1'b0; tvalid = 1'b0; tlast = 1'b1; tdata = '0; ctrl_en = 1'b1;
    div = '0; cpol = 1'b1; cpha = 1'b0; lsb = 1'b0; sspol = 1'b1; flen = '0; sel = '0;
    repeat (3) @(negedge clk);
    check("rst_tready", tready, 0);
    check("rst_busy", busy, 0);
    check("rst_sclk", sclk, 0);
    check("rst_sdo", sdo, 0);
    check("rst_sdo_en", sdo_en, 0);
    check("rst_cs", cs_no, 3'b111);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cs_level", cs_no, 3'b000);
    check("idle_sclk_cpol", sclk, 1);
    check("idle_tready", tready, 1);
    cpol = 1'b0; sspol = 1'b0;
    repeat (2) @(negedge clk);

    // Mode 0, MSB first, 0xA5, H=2.
    run(16'h00A5, 7, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 1'b1, 1'b0);
    // Mode 3, LSB first, 0x6, active-high CS on index 2.
    run(16'h0006, 3, 1'b1, 1'b1, 1'b1, 1'b1, 2, 1, 1'b1, 1'b0);
    // Out-of-range chip select still clocks the frame.
    run(16'h3C5A, 9, 1'b0, 1'b1, 1'b0, 1'b0, 3, 0, 1'b1, 1'b0);
    // Largest divider.
    run(16'hBEEF, 5, 1'b1, 1'b0, 1'b1, 1'b0, 1, 7, 1'b1, 1'b1);

    // Loaded word waits indefinitely for sync.
    send(16'h1234, 11, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    bad = 0;
    ref_sclk = sclk;
    repeat (100) begin
      @(negedge clk);
      if (tready !== 1'b0 || busy !== 1'b1 || sdo_en !== 1'b0 || sclk !== ref_sclk) bad++;
    end
    check("loaded_wait", bad, 0);
    sync_pulse(0);
    check("setup_after_sync", {busy, sdo_en}, 2'b11);
    wait_idle();

    // Disable during bit 3 of a 16-bit frame (H=1).
    send(16'hF0F0, 15, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 1'b1, 1'b1, 1'b0);
    sync_pulse(0);
    repeat (7) @(negedge clk);
    ctrl_en = 1'b0;
    @(negedge clk);
    check("abort_cs", cs_no, 3'b111);
    check("abort_sclk", sclk, 1);
    check("abort_busy", busy, 0);
    check("abort_sdo_en", sdo_en, 0);
    ctrl_en = 1'b1;
    @(negedge clk);
    run(16'h0F0F, 15, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0);

    // Reset in the middle of a frame.
    send(16'h5555, 12, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 1'b1, 1'b1, 1'b0);
    sync_pulse(0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {tready, busy, sclk, sdo, sdo_en}, 5'b00000);
    check("midrst_cs", cs_no, 3'b111);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized frames with the live configuration scrambled mid-frame.
    for (int t = 0; t < 20; t++) begin
      run(W'($urandom), $urandom_range(0, W - 1), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), $urandom_range(0, 3), $urandom_range(0, 7), 1'($urandom), 1'b1);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
